// File: rtl/frog_game_ctrl.sv
// Purpose : frame-synchronous frog game sequencer (position, lives, score, PLAY/SCAN/HIT/WIN/OVER).
// Latency : moves commit 1 clk after a button edge; collision scan takes 16 clk, HIT is visible <= 17 clk after frame_tick.
// Backpressure: none; edges during SCAN are held in a 1-deep pending slot, edges in HIT/WIN are dropped.
module frog_game_ctrl #(
   parameter int GRID_COLS     = 20,
   parameter int GRID_ROWS     = 15,
   parameter int START_COL     = 9,
   parameter int MOVE_COOLDOWN = 4,
   parameter int HIT_FRAMES    = 60,
   parameter int WIN_FRAMES    = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [79:0] car_x_flat,
   input  logic [63:0] car_y_flat,
   output logic [4:0]  frog_col,
   output logic [3:0]  frog_row,
   output logic [1:0]  lives,
   output logic [7:0]  score,
   output logic        hit_flash,
   output logic        game_over,
   output logic        win_pulse
);

   typedef enum logic [2:0] {S_PLAY, S_SCAN, S_HIT, S_WIN, S_OVER} state_t;

   localparam logic [1:0] D_UP    = 2'd0;
   localparam logic [1:0] D_DOWN  = 2'd1;
   localparam logic [1:0] D_LEFT  = 2'd2;
   localparam logic [1:0] D_RIGHT = 2'd3;

   localparam logic [4:0] COL_START = 5'(START_COL);
   localparam logic [3:0] ROW_START = 4'(GRID_ROWS - 1);
   localparam logic [4:0] COL_MAX   = 5'(GRID_COLS - 1);
   localparam logic [3:0] ROW_MAX   = 4'(GRID_ROWS - 1);
   localparam logic [7:0] CD_LOAD   = 8'(MOVE_COOLDOWN);
   localparam logic [7:0] HIT_LAST  = 8'(HIT_FRAMES - 1);
   localparam logic [7:0] WIN_LAST  = 8'(WIN_FRAMES - 1);

   state_t      state;
   logic [3:0]  btn_q;
   logic [7:0]  cooldown;
   logic [7:0]  frm_cnt;
   logic [3:0]  idx;
   logic        pend_vld;
   logic [1:0]  pend_dir;

   logic        req_vld;
   logic [1:0]  req_dir;
   logic        act_vld;
   logic [1:0]  act_dir;
   logic        move_ok;
   logic [4:0]  nxt_col;
   logic [3:0]  nxt_row;
   logic [6:0]  x_base;
   logic [5:0]  y_base;
   logic [4:0]  car_x;
   logic [3:0]  car_y;
   logic        car_hit;

   // Rising-edge detection with fixed priority up > down > left > right.
   always_comb begin
      req_vld = 1'b1;
      req_dir = D_UP;
      if (btn_up && !btn_q[0])
         req_dir = D_UP;
      else if (btn_down && !btn_q[1])
         req_dir = D_DOWN;
      else if (btn_left && !btn_q[2])
         req_dir = D_LEFT;
      else if (btn_right && !btn_q[3])
         req_dir = D_RIGHT;
      else
         req_vld = 1'b0;
   end

   // Next frog position: a fresh edge beats the pending slot, moves clamp at the grid edges.
   always_comb begin
      act_vld = req_vld || pend_vld;
      act_dir = req_vld ? req_dir : pend_dir;
      move_ok = (state == S_PLAY) && act_vld && (cooldown == 8'd0);
      nxt_col = frog_col;
      nxt_row = frog_row;
      if (move_ok) begin
         case (act_dir)
            D_UP:    nxt_row = (frog_row == 4'd0)    ? frog_row : frog_row - 4'd1;
            D_DOWN:  nxt_row = (frog_row >= ROW_MAX) ? frog_row : frog_row + 4'd1;
            D_LEFT:  nxt_col = (frog_col == 5'd0)    ? frog_col : frog_col - 5'd1;
            default: nxt_col = (frog_col >= COL_MAX) ? frog_col : frog_col + 5'd1;
         endcase
      end
   end

   // Select the car under test this scan cycle and compare it with the frog.
   always_comb begin
      x_base  = 7'(idx) * 7'd5;
      y_base  = {idx, 2'b00};
      car_x   = car_x_flat[x_base +: 5];
      car_y   = car_y_flat[y_base +: 4];
      car_hit = (car_x == frog_col) && (car_y == frog_row);
   end

   // Game sequencer: state, position, lives, score and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_PLAY;
         btn_q     <= 4'd0;
         frog_col  <= COL_START;
         frog_row  <= ROW_START;
         lives     <= 2'd3;
         score     <= 8'd0;
         cooldown  <= 8'd0;
         frm_cnt   <= 8'd0;
         idx       <= 4'd0;
         pend_vld  <= 1'b0;
         pend_dir  <= D_UP;
         hit_flash <= 1'b0;
         game_over <= 1'b0;
         win_pulse <= 1'b0;
      end else begin
         btn_q     <= {btn_right, btn_left, btn_down, btn_up};
         win_pulse <= 1'b0;
         case (state)
            S_PLAY: begin
               pend_vld <= 1'b0;
               frog_col <= nxt_col;
               frog_row <= nxt_row;
               if (move_ok)
                  cooldown <= CD_LOAD;
               else if (frame_tick && cooldown != 8'd0)
                  cooldown <= cooldown - 8'd1;
               if (frame_tick) begin
                  if (nxt_row == 4'd0) begin
                     state     <= S_WIN;
                     score     <= (score == 8'hFF) ? score : score + 8'd1;
                     win_pulse <= 1'b1;
                     frog_col  <= COL_START;
                     frog_row  <= ROW_START;
                     frm_cnt   <= 8'd0;
                  end else begin
                     state <= S_SCAN;
                     idx   <= 4'd0;
                  end
               end
            end
            S_SCAN: begin
               if (req_vld) begin
                  pend_vld <= 1'b1;
                  pend_dir <= req_dir;
               end
               if (car_hit) begin
                  pend_vld <= 1'b0;
                  frog_col <= COL_START;
                  frog_row <= ROW_START;
                  frm_cnt  <= 8'd0;
                  if (lives <= 2'd1) begin
                     lives     <= 2'd0;
                     state     <= S_OVER;
                     game_over <= 1'b1;
                  end else begin
                     lives     <= lives - 2'd1;
                     state     <= S_HIT;
                     hit_flash <= 1'b1;
                  end
               end else if (idx == 4'd15) begin
                  state <= S_PLAY;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            S_HIT: begin
               if (frame_tick) begin
                  if (frm_cnt == HIT_LAST) begin
                     state     <= S_PLAY;
                     hit_flash <= 1'b0;
                  end else begin
                     frm_cnt <= frm_cnt + 8'd1;
                  end
               end
            end
            S_WIN: begin
               if (frame_tick) begin
                  if (frm_cnt == WIN_LAST)
                     state <= S_PLAY;
                  else
                     frm_cnt <= frm_cnt + 8'd1;
               end
            end
            S_OVER: begin
               frog_col <= COL_START;
               frog_row <= ROW_START;
               if (req_vld) begin
                  lives     <= 2'd3;
                  score     <= 8'd0;
                  cooldown  <= 8'd0;
                  pend_vld  <= 1'b0;
                  game_over <= 1'b0;
                  state     <= S_PLAY;
               end
            end
            default: state <= S_PLAY;
         endcase
      end
   end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Purpose : self-checking bench for frog_game_ctrl using a queue of expected output snapshots.
// Latency : expectations are pushed when stimulus is driven and popped once the DUT has reacted.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_frog_game_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        btn_up, btn_down, btn_left, btn_right;
   logic [79:0] car_x_flat;
   logic [63:0] car_y_flat;
   logic [4:0]  frog_col;
   logic [3:0]  frog_row;
   logic [1:0]  lives;
   logic [7:0]  score;
   logic        hit_flash, game_over, win_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // snapshot = {col, row, lives, score, hit_flash, game_over}
   logic [20:0] sb[$];
   logic [20:0] exp_s;
   logic [20:0] obs_s;

   frog_game_ctrl dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .car_x_flat(car_x_flat), .car_y_flat(car_y_flat),
      .frog_col(frog_col), .frog_row(frog_row), .lives(lives), .score(score),
      .hit_flash(hit_flash), .game_over(game_over), .win_pulse(win_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] pk(input int c, input int r, input int l, input int s,
                                      input int h, input int o);
      return {5'(c), 4'(r), 2'(l), 8'(s), 1'(h), 1'(o)};
   endfunction

   function automatic logic [20:0] snap();
      return {frog_col, frog_row, lives, score, hit_flash, game_over};
   endfunction

   // All cars off-grid (column 31 never matches a column 0..19).
   task automatic cars_clear();
      car_x_flat = {16{5'd31}};
      car_y_flat = {16{4'd15}};
   endtask

   task automatic place_car(input int n, input int c, input int r);
      car_x_flat[n*5 +: 5] = 5'(c);
      car_y_flat[n*4 +: 4] = 4'(r);
   endtask

   // Tasks are entered and left 1 time unit after a rising edge.
   task automatic do_reset();
      rst = 1'b1; frame_tick = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      cars_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk); #1 frame_tick = 1'b0;
         repeat (39) @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int d);
      case (d)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         2: btn_left = 1'b1;
         default: btn_right = 1'b1;
      endcase
      @(posedge clk); #1;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL reset_state: got %h expected %h", obs_s, exp_s); end
      n_checks++;
      if (win_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_win_pulse: got %b expected 0", win_pulse); end
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      frames(10);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL idle_10_frames: got %h expected %h", obs_s, exp_s); end
   endtask

   task automatic test_win();
      int pulses;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         frames(5);
         sb.push_back(pk(9, 13 - i, 3, 0, 0, 0));
         press(0);
         exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
         if (obs_s !== exp_s) begin n_fail++; $display("FAIL win_step_%0d: got %h expected %h", i, obs_s, exp_s); end
      end
      sb.push_back(pk(9, 14, 3, 1, 0, 0));
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (win_pulse === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL win_pulse_width: got %0d cycles expected 1", pulses); end
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL win_entry: got %h expected %h", obs_s, exp_s); end
      @(posedge clk); #1;
      // 30 frames in WIN, then 3 more to drain the leftover cooldown before moving again.
      frames(33);
      sb.push_back(pk(9, 13, 3, 1, 0, 0));
      press(0);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL play_after_win: got %h expected %h", obs_s, exp_s); end
   endtask

   task automatic test_left_clamp();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         press(2);
         frames(5);
      end
      sb.push_back(pk(0, 14, 3, 0, 0, 0));
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL reach_col0: got %h expected %h", obs_s, exp_s); end
      sb.push_back(pk(0, 14, 3, 0, 0, 0));
      press(2);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL left_clamp: got %h expected %h", obs_s, exp_s); end
      frames(2);
      sb.push_back(pk(0, 14, 3, 0, 0, 0));
      press(2);
      press(3);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL cooldown_drop: got %h expected %h", obs_s, exp_s); end
      frames(2);
      sb.push_back(pk(1, 14, 3, 0, 0, 0));
      press(3);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL cooldown_expired: got %h expected %h", obs_s, exp_s); end
   endtask

   task automatic test_hit();
      int k;
      do_reset();
      place_car(11, 9, 14);
      sb.push_back(pk(9, 14, 2, 0, 1, 0));
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      k = 0;
      while (hit_flash !== 1'b1 && k <= 20) begin
         @(posedge clk); #1;
         k++;
      end
      n_checks++;
      if (hit_flash !== 1'b1 || k > 17) begin
         n_fail++; $display("FAIL hit_latency: got %0d clk (hit_flash=%b) expected <= 17", k, hit_flash);
      end
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL hit_entry: got %h expected %h", obs_s, exp_s); end
      cars_clear();
      sb.push_back(pk(9, 14, 2, 0, 1, 0));
      press(0);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL hit_ignores_button: got %h expected %h", obs_s, exp_s); end
      sb.push_back(pk(9, 14, 2, 0, 1, 0));
      frames(59);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL hit_held_59: got %h expected %h", obs_s, exp_s); end
      sb.push_back(pk(9, 14, 2, 0, 0, 0));
      frames(1);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL hit_release_60: got %h expected %h", obs_s, exp_s); end
   endtask

   task automatic test_game_over();
      do_reset();
      place_car(0, 9, 14);
      sb.push_back(pk(9, 14, 2, 0, 1, 0));
      sb.push_back(pk(9, 14, 1, 0, 1, 0));
      sb.push_back(pk(9, 14, 0, 0, 0, 1));
      frames(1);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL over_hit1: got %h expected %h", obs_s, exp_s); end
      frames(61);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL over_hit2: got %h expected %h", obs_s, exp_s); end
      frames(61);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL over_entry: got %h expected %h", obs_s, exp_s); end
      sb.push_back(pk(9, 14, 0, 0, 0, 1));
      frames(2);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL over_no_underflow: got %h expected %h", obs_s, exp_s); end
      cars_clear();
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      press(3);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL over_restart: got %h expected %h", obs_s, exp_s); end
   endtask

   task automatic test_back_to_back();
      int k;
      // Move and frame_tick in the same cycle: scan sees the new row 13.
      do_reset();
      place_car(5, 9, 13);
      sb.push_back(pk(9, 14, 2, 0, 1, 0));
      btn_up = 1'b1; frame_tick = 1'b1;
      @(posedge clk); #1 btn_up = 1'b0; frame_tick = 1'b0;
      k = 0;
      while (hit_flash !== 1'b1 && k <= 20) begin
         @(posedge clk); #1;
         k++;
      end
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL same_cycle_move_hit: got %h expected %h", obs_s, exp_s); end
      // Reset in the middle of HIT.
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      rst = 1'b1;
      @(posedge clk); #1;
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL rst_mid_hit: got %h expected %h", obs_s, exp_s); end
      rst = 1'b0;
      cars_clear();
      @(posedge clk); #1;
      // Reset in the middle of SCAN.
      press(3);
      sb.push_back(pk(10, 14, 3, 0, 0, 0));
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL move_before_scan: got %h expected %h", obs_s, exp_s); end
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      @(posedge clk); #1;
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL rst_mid_scan: got %h expected %h", obs_s, exp_s); end
      rst = 1'b0;
      @(posedge clk); #1;
      // Edge during SCAN is held and applied when PLAY resumes.
      frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      sb.push_back(pk(9, 14, 3, 0, 0, 0));
      sb.push_back(pk(9, 13, 3, 0, 0, 0));
      press(0);
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL pending_held: got %h expected %h", obs_s, exp_s); end
      repeat (20) @(posedge clk);
      #1;
      exp_s = sb.pop_front(); obs_s = snap(); n_checks++;
      if (obs_s !== exp_s) begin n_fail++; $display("FAIL pending_applied: got %h expected %h", obs_s, exp_s); end
   endtask

   initial begin
      test_reset();
      test_win();
      test_left_clamp();
      test_hit();
      test_game_over();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
